// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {dp,g,f,e,d,c,b,a} and a width helper for select/index ports.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Width of a selector over n items, never less than one bit.
    function automatic int pw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern; dp held off.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned page snapshots.
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_PAGES  = 2,
    parameter int PRESCALE   = 10000,
    parameter int LZ_BLANK   = 0
)
(
    input  logic                              clk50MHz,
    input  logic                              rst,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
    input  logic [pw_width(NUM_PAGES)-1:0]    page_sel,
    input  logic                              clear,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]             blink_mask,
`endif
    output logic [7:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an,
    output logic                              frame_done
);

    localparam int PW  = pw_width(NUM_PAGES);
    localparam int DW  = pw_width(NUM_DIGITS);
    localparam int PCW = $clog2(PRESCALE);
    localparam int SW  = NUM_DIGITS * 4;

    logic [PCW-1:0]        pcnt_q, pcnt_d;
    logic [DW-1:0]         didx_q, didx_d;
    logic [PW-1:0]         act_page_q, act_page_d;
    logic [SW-1:0]         snap_q, snap_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;
`ifdef SEG_BLINK_EN
    logic [7:0]            fcnt_q, fcnt_d;
`endif

    logic                  tick;
    logic                  frame_bnd;
    logic                  blank_dig;
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_nib;
    logic [7:0]            cur_seg;
    logic [SW-1:0]         page_arr [NUM_PAGES];
    logic [3:0]            snap_dig [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
            assign page_arr[gi] = page_data[gi*SW +: SW];
        end
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign snap_dig[gi] = snap_q[gi*4 +: 4];
        end
    endgenerate

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always stays lit.
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run      = lz_run && (snap_dig[i] == 4'd0);
            lz_blank[i] = lz_run;
        end
    end

    assign cur_nib = snap_dig[didx_q];

    hex7seg_decode u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    always_comb begin
        tick         = (pcnt_q == PCW'(PRESCALE - 1));
        frame_bnd    = tick && (didx_q == DW'(NUM_DIGITS - 1));
        pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
        didx_d       = didx_q;
        act_page_d   = act_page_q;
        snap_d       = snap_q;
        frame_done_d = frame_bnd;

        if (tick) begin
            didx_d = (didx_q == DW'(NUM_DIGITS - 1)) ? '0 : didx_q + 1'b1;
        end

        // Page switches land only on frame boundaries so a frame never tears.
        if (frame_bnd) begin
            if (32'(page_sel) < NUM_PAGES) begin
                act_page_d = page_sel;
            end
            snap_d = page_arr[act_page_d];
        end

        blank_dig = (LZ_BLANK != 0) && lz_blank[didx_q];
`ifdef SEG_BLINK_EN
        fcnt_d    = frame_bnd ? fcnt_q + 8'd1 : fcnt_q;
        blank_dig = blank_dig || (fcnt_q[7] && blink_mask[didx_q]);
`endif

        if (clear) begin
            seg_d = SEG_BLANK;
            an_d  = '1;
        end else begin
            seg_d = blank_dig ? SEG_BLANK : cur_seg;
            an_d  = ~(NUM_DIGITS'(1) << didx_q);
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            pcnt_q       <= '0;
            didx_q       <= '0;
            act_page_q   <= '0;
            snap_q       <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
`ifdef SEG_BLINK_EN
            fcnt_q       <= '0;
`endif
        end else begin
            pcnt_q       <= pcnt_d;
            didx_q       <= didx_d;
            act_page_q   <= act_page_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
`ifdef SEG_BLINK_EN
            fcnt_q       <= fcnt_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: two instances (plain and with
// leading-zero blanking) checked every cycle against a slot/frame model.
module tb_seg_scan_driver;

    localparam int P  = 4;
    localparam int ND = 4;
    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] page_data;
    logic [0:0]  page_sel;
    logic        clear;
    logic [3:0]  blink_mask;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int tests = 0;
    int fails = 0;

    // model state
    int          c;
    int          m_page;
    logic [3:0]  m_snap [ND];
    logic [7:0]  m_frames;
    logic [7:0]  exp_seg, exp_seg_lz;
    logic [3:0]  exp_an;
    logic        exp_fd;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .PRESCALE(P), .LZ_BLANK(0)) dut (
        .clk50MHz   (clk),
        .rst        (rst),
        .page_data  (page_data),
        .page_sel   (page_sel),
        .clear      (clear),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg_a),
        .an         (an_a),
        .frame_done (fd_a)
    );

    seg_scan_driver #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .PRESCALE(P), .LZ_BLANK(1)) dut_lz (
        .clk50MHz   (clk),
        .rst        (rst),
        .page_data  (page_data),
        .page_sel   (page_sel),
        .clear      (clear),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg_b),
        .an         (an_b),
        .frame_done (fd_b)
    );

    function automatic logic [7:0] hex2seg(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    task automatic model_reset();
        c        = 0;
        m_page   = 0;
        m_frames = 8'd0;
        for (int i = 0; i < ND; i++) m_snap[i] = 4'd0;
    endtask

    task automatic check_outputs();
        tests++;
        assert (seg_a === exp_seg) else begin
            fails++; $error("FAIL seg cyc=%0d got=%h exp=%h", c, seg_a, exp_seg);
        end
        tests++;
        assert (an_a === exp_an) else begin
            fails++; $error("FAIL an cyc=%0d got=%b exp=%b", c, an_a, exp_an);
        end
        tests++;
        assert (fd_a === exp_fd) else begin
            fails++; $error("FAIL frame_done cyc=%0d got=%b exp=%b", c, fd_a, exp_fd);
        end
        tests++;
        assert (seg_b === exp_seg_lz) else begin
            fails++; $error("FAIL seg_lz cyc=%0d got=%h exp=%h", c, seg_b, exp_seg_lz);
        end
        tests++;
        assert (an_b === exp_an) else begin
            fails++; $error("FAIL an_lz cyc=%0d got=%b exp=%b", c, an_b, exp_an);
        end
        tests++;
        assert (fd_b === exp_fd) else begin
            fails++; $error("FAIL frame_done_lz cyc=%0d got=%b exp=%b", c, fd_b, exp_fd);
        end
    endtask

    // One clock: sample inputs as the DUT will see them, advance the model
    // by one edge, then compare just after the edge.
    task automatic cycle();
        logic        r, cl, lead;
        logic [0:0]  ps;
        logic [31:0] pd;
        logic [3:0]  bm;
        int          d;
        r  = rst;
        cl = clear;
        ps = page_sel;
        pd = page_data;
        bm = blink_mask;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
            exp_seg    = 8'hFF;
            exp_seg_lz = 8'hFF;
            exp_an     = 4'hF;
            exp_fd     = 1'b0;
        end else begin
            d          = (c / P) % ND;
            exp_seg    = hex2seg(m_snap[d]);
            exp_seg_lz = exp_seg;
            lead       = (d > 0);
            for (int i = d; i < ND; i++) if (m_snap[i] != 4'd0) lead = 1'b0;
            if (lead) exp_seg_lz = 8'hFF;
`ifdef SEG_BLINK_EN
            if (m_frames[7] && bm[d]) begin
                exp_seg    = 8'hFF;
                exp_seg_lz = 8'hFF;
            end
`else
            if (bm === 4'hx) exp_seg = 8'hxx;
`endif
            if (cl) begin
                exp_seg    = 8'hFF;
                exp_seg_lz = 8'hFF;
                exp_an     = 4'hF;
            end else begin
                exp_an = ~(4'b0001 << d);
            end
            exp_fd = ((c % (P * ND)) == P * ND - 1);
            if (exp_fd) begin
                if (int'(ps) < NP) m_page = int'(ps);
                for (int i = 0; i < ND; i++) m_snap[i] = pd[(m_page*ND + i)*4 +: 4];
                m_frames = m_frames + 8'd1;
            end
            c++;
        end
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst        = 1'b1;
        page_data  = 32'h0;
        page_sel   = 1'b0;
        clear      = 1'b0;
        blink_mask = 4'b0001;
        model_reset();

        // reset held, then a frame of zeros from page 0
        run(3);
        rst = 1'b0;
        run(16);

        // scan and decode of 1A3F
        page_data[15:0] = 16'h1A3F;
        run(40);

        // tear-free page switch raised mid-frame
        page_data[31:16] = 16'h9999;
        run(5);
        page_sel = 1'b1;
        run(40);
        page_sel = 1'b0;
        run(20);

        // leading-zero patterns
        page_data[15:0] = 16'h0050;
        run(36);
        page_data[15:0] = 16'h0000;
        run(36);
        page_data[15:0] = 16'h8001;
        run(36);

        // clear asserted mid-slot, then released
        run(2);
        clear = 1'b1;
        run(6);
        clear = 1'b0;
        run(12);

        // reset mid-frame
        page_data = 32'h4321_DCBA;
        run(25);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(40);

        // randomized inputs changing at arbitrary cycles
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) page_data = $urandom;
            if ($urandom_range(0, 9) == 0) page_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) clear = ~clear;
            if ($urandom_range(0, 63) == 0) page_data[15:0] = 16'($urandom_range(0, 255));
            cycle();
        end
        clear = 1'b0;
        run(8);

`ifdef SEG_BLINK_EN
        // run through the blink off phase, then restart it with a reset
        page_data = 32'h0000_5678;
        page_sel  = 1'b0;
        run(260 * P * ND);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(40);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout after %0d checks", tests);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode LED digits. Holds `NUM_PAGES` pages of `NUM_DIGITS` hex nibbles (operands, ALU results, state) and scans one digit at a time at a prescaled rate. A page switch or data update never tears a frame. It replaces the static per-digit decode-and-mux display path with one scanned segment bus plus per-digit anode enables.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned per frame (≥1).
- `NUM_PAGES`, 2: selectable pages (≥1).
- `PRESCALE`, 10000: `clk50MHz` cycles per digit slot (≥2); 10000 gives a 5 kHz digit rate.
- `LZ_BLANK`, 0: 1 enables leading-zero blanking.

Ports (reset is synchronous, active-high; single clock):
- `clk50MHz`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `page_data`  in  `NUM_PAGES*NUM_DIGITS*4`: nibble for page p, digit d at bits `[(p*NUM_DIGITS+d)*4 +: 4]`; digit 0 is rightmost.
- `page_sel`  in  `PW = max(1,$clog2(NUM_PAGES))`: requested page.
- `clear`  in  1: level; while high, all digits are blank.
- `blink_mask`  in  `NUM_DIGITS`: per-digit blink enable (present only with `SEG_BLINK_EN`).
- `seg`  out  8: `{dp,g,f,e,d,c,b,a}`, active-low; dp is always 1.
- `an`  out  `NUM_DIGITS`: active-low anode enables, one-hot-low.
- `frame_done`  out  1: one-cycle pulse at each frame boundary.

## Operation
- Prescaler `pcnt` counts 0..`PRESCALE-1` and wraps. `tick` = (`pcnt == PRESCALE-1`).
- Digit index `didx` advances on `tick`, wrapping from `NUM_DIGITS-1` to 0.
- Frame boundary = `tick` while `didx == NUM_DIGITS-1`. At a frame boundary:
  - `page_sel` is sampled into `act_page`. A value ≥ `NUM_PAGES` is ignored and `act_page` is held.
  - The selected page's nibbles are copied into `snap`, using the new `act_page` value.
- Display data comes only from `snap`. Changes to `page_data` or `page_sel` between boundaries have no visible effect.
- Decode: 0–9 and A–F map to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- With `LZ_BLANK=1`: digits from the MSB downward are blanked (8'hFF) while their nibble is 0, stopping at the first nonzero digit. Digit 0 is never blanked.
- `clear` high forces `seg=8'hFF` and `an` all ones. Counters keep running and `snap` still updates.
- Reset values: `pcnt=0`, `didx=0`, `act_page=0`, `snap=0`, `seg=8'hFF`, `an` all ones, `frame_done=0`.
- Reset asserted mid-frame returns every register to its reset value on the next edge. The first frame after reset displays zeros from page 0.

## Timing
- `didx` changes on the edge after `tick`.
- `seg` and `an` are registered from (`didx`, `snap`, `clear`). They lag `didx` by exactly one cycle, and `seg` and `an` change on the same edge.
- `frame_done` is registered high for exactly one cycle, on the same edge that wraps `didx` to 0.
- A digit slot is `PRESCALE` cycles; a frame is `NUM_DIGITS*PRESCALE` cycles.
- Latency from `page_sel` change to the new page on `seg`: up to one frame plus 1 cycle.
- `clear` takes effect on `seg`/`an` one cycle after it is asserted, and is released one cycle after it deasserts.

## Configuration
- Macro `SEG_BLINK_EN`:
  - Defined: `blink_mask` port exists. An 8-bit frame counter increments on each frame boundary; its MSB is the blink phase (128 frames on, 128 off). A digit whose `blink_mask` bit is 1 is blanked during the off phase. Reset clears the frame counter.
  - Undefined: no port and no counter; all digits display continuously.

## Structure
- Package `seg_pkg` holds:
  - `SEG_BLANK = 8'hFF` and the 16 hex segment constants.
  - The `PW` width function.
- Sub-module `hex7seg_decode`: combinational 4-bit nibble to 8-bit active-low segment pattern; dp fixed at 1.
- Everything else (counters, snapshot, blanking, output registers) lives in `seg_scan_driver`.

## Test plan
All scenarios use `PRESCALE=4`, `NUM_DIGITS=4`, `NUM_PAGES=2`.
- **Reset:** hold `rst` for 3 cycles → `seg=FF`, `an=1111`, `frame_done=0`. The first frame shows `seg=C0` on each of `an=1110`, `1101`, `1011`, `0111` in turn, 4 cycles each.
- **Scan and decode:** page0=16'h1A3F → slots show F9@1110... wait, digit order is digit 0 first. Digit 0=F shows 8E with `an=1110`, then digit 1=3 shows B0, digit 2=A shows 88, digit 3=1 shows F9. `frame_done` pulses once every 16 cycles.
- **Tear-free page switch:** page1=16'h9999; raise `page_sel`=1 mid-frame → the current frame still shows page 0; the next frame shows 90 on all digits. `page_sel=2` has no effect on a 2-page build.
- **Leading-zero blanking:** `LZ_BLANK=1`, page0=16'h0050 → digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0. page0=0 → only digit 0 lit (C0).
- **Clear:** assert `clear` mid-slot → `seg=FF` and `an=1111` one cycle later. Deassert → scanning resumes at the current `didx` with no phase reset.
- **Blink (`SEG_BLINK_EN`):** `blink_mask=0001` → digit 0 is FF for frames 128–255 while other digits stay lit. Reset mid-test restarts the on phase.
